final_soc_onchip_mem_arbiter: RTL and testbench
===============================================

// Module: final_soc_onchip_mem_arbiter
// PURPOSE
//  Shares the 4-word x 32-bit single-port on-chip RAM between NREQ Avalon-MM requesters.
//  Typical requesters: the Nios II data master and a hardware accelerator.
//  Round-robin arbitration, one command per cycle, waitrequest/readdatavalid handshake.
//  Drives the RAM's address/byteenable/chipselect/write/writedata/clken and honours reset_req.
//  Sits between the requesters and the RAM slave inside final_soc.
// PARAMETERS
//  NREQ    2   number of requesters (2..4)
//  ADDR_W  2   word address width; matches the RAM depth of 4
//  DATA_W  32  data width; byteenable width is DATA_W/8
// PORTS
//  clk             in   1              system clock
//  reset_n         in   1              asynchronous, active-low reset
//  req_address     in   NREQ*ADDR_W    per-requester word address; requester i at slice i
//  req_byteenable  in   NREQ*DATA_W/8  per-requester byte enables
//  req_read        in   NREQ           per-requester read request
//  req_write       in   NREQ           per-requester write request
//  req_writedata   in   NREQ*DATA_W    per-requester write data
//  req_waitrequest out  NREQ           high = command not accepted this cycle
//  req_readdatavalid out NREQ          one-cycle strobe: req_readdata is valid for requester i
//  req_readdata    out  DATA_W         shared read data bus, qualified by req_readdatavalid
//  freeze          in   1              high = accept no new commands
//  reset_req       in   1              RAM reset request; blocks grants and gates clken
//  mem_address     out  ADDR_W         RAM address
//  mem_byteenable  out  DATA_W/8       RAM byte enables
//  mem_chipselect  out  1              RAM chip select
//  mem_write       out  1              RAM write enable
//  mem_writedata   out  DATA_W         RAM write data
//  mem_clken       out  1              RAM clock enable
//  mem_readdata    in   DATA_W         RAM q; valid the cycle after the address edge
// BEHAVIOUR
//  - Reset (reset_n low, asynchronous):
//    - rr_ptr=0; rdv_pipe=0; rd_owner=0.
//    - req_readdatavalid=0; req_waitrequest=all 1s; mem_chipselect=0; mem_write=0.
//  - Request: requester i requests when req_read[i] | req_write[i].
//    - read and write both high is illegal; treat it as a write and flag it with an assertion.
//  - Grant condition: reset_n & ~freeze & ~reset_req & any request.
//    - Winner is the first requesting index at or after rr_ptr, modulo NREQ. Grant is combinational.
//  - While granted:
//    - req_waitrequest[win]=0; every other requester's waitrequest=1.
//    - The winner's address/byteenable/writedata are muxed onto mem_*.
//    - mem_chipselect=1; mem_write=req_write[win].
//  - With no grant: waitrequest=1 for all; mem_chipselect=0; mem_write=0.
//    - mem_address, mem_byteenable and mem_writedata hold their last muxed values (don't-care).
//  - mem_clken = ~reset_req.
//  - Pointer: on each accepted command, rr_ptr <= win+1 (wraps NREQ-1 -> 0). rr_ptr holds when idle.
//  - Write latency: committed at the accepting edge; no response.
//  - Read latency:
//    - Accepted at edge N; rdv_pipe and rd_owner<=win register at edge N.
//    - In cycle N+1: req_readdatavalid[rd_owner]=1 and req_readdata=mem_readdata.
//  - Back-to-back reads:
//    - A new command may be accepted in the same cycle a prior read returns.
//    - Throughput is 1 command/cycle with no bubbles.
//  - Read-during-write to the same address is DONT_CARE at the RAM; the arbiter adds no forwarding.
//  - reset_req/freeze rising while a read is in flight:
//    - That read's readdatavalid still fires in the next cycle.
//    - No new grants until both drop.
//  - A requester with waitrequest=1 must hold its command stable (Avalon rule); no grant is revoked.
//  - Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ cycles.
//  - reset_n asserted mid-read: the pending readdatavalid is discarded (rdv_pipe cleared).
// STRUCTURE
//  - Package final_soc_mem_arb_pkg:
//    - localparam REQ_IDX_W = $clog2(NREQ).
//    - typedef arb_cmd_t {addr, be, wdata, we} for the muxed command.
//  - One sub-module, final_soc_rr_picker: combinational round-robin picker.
//    - Inputs: req[NREQ-1:0] and ptr. Outputs: win index and any_grant.
//    - Reused by future shared-slave arbiters.
//  - Top level holds rr_ptr, the read-return pipe and the command mux.
// TESTING
//  1. Reset, then m0 writes addr1 0xDEADBEEF (be=4'hF); m0 reads addr1
//     -> waitrequest low each cycle; readdatavalid[0] next cycle with data 0xDEADBEEF.
//  2. m0 and m1 both read continuously for 8 cycles from rr_ptr=0
//     -> grants alternate 0,1,0,1...; readdatavalid follows one cycle later with matching owner.
//  3. m1 writes addr2 0x11223344 with be=4'b0101 over 0xFFFFFFFF, then reads addr2
//     -> returns 0xFF22FF44.
//  4. m0 read accepted; reset_req=1 next cycle for 3 cycles
//     -> readdatavalid[0] still fires; waitrequest=1 and mem_clken=0 for those 3 cycles.
//  5. freeze=1 with both requesting -> no chipselect, all waitrequest high.
//     freeze=0 -> grant goes to the rr_ptr owner.
//  6. reset_n low in the cycle after a read accept
//     -> no readdatavalid; all outputs at reset values asynchronously.

Source files
------------

// File: rtl/final_soc_mem_arb_pkg.sv
// Shared types and constants for the on-chip RAM arbiter and its round-robin picker.
package final_soc_mem_arb_pkg;
  // Index width covers the largest supported requester count (2..4).
  localparam int NREQ_MAX   = 4;
  localparam int REQ_IDX_W  = $clog2(NREQ_MAX);
  localparam int ARB_ADDR_W = 2;
  localparam int ARB_DATA_W = 32;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W/8-1:0] be;
    logic [ARB_DATA_W-1:0]   wdata;
    logic                    we;
  } arb_cmd_t;
endpackage

// File: rtl/final_soc_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after ptr, modulo NREQ.
module final_soc_rr_picker
  import final_soc_mem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]      req_i,
  input  logic [REQ_IDX_W-1:0] ptr_i,
  output logic [REQ_IDX_W-1:0] win_o,
  output logic                 any_o
);
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] rot;

  // Rotating a doubled copy puts the ptr'th requester at bit 0.
  assign dbl = {req_i, req_i};
  assign rot = dbl >> ptr_i;

  always_comb begin
    int sum;
    win_o = '0;
    any_o = 1'b0;
    sum   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum   = int'(ptr_i) + k;
        win_o = REQ_IDX_W'((sum >= NREQ) ? sum - NREQ : sum);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/final_soc_onchip_mem_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip RAM between NREQ Avalon-MM requesters.
module final_soc_onchip_mem_arbiter
  import final_soc_mem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ*ADDR_W-1:0]   req_address,
  input  logic [NREQ*DATA_W/8-1:0] req_byteenable,
  input  logic [NREQ-1:0]          req_read,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*DATA_W-1:0]   req_writedata,
  output logic [NREQ-1:0]          req_waitrequest,
  output logic [NREQ-1:0]          req_readdatavalid,
  output logic [DATA_W-1:0]        req_readdata,
  input  logic                     freeze,
  input  logic                     reset_req,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W/8-1:0]      mem_byteenable,
  output logic                     mem_chipselect,
  output logic                     mem_write,
  output logic [DATA_W-1:0]        mem_writedata,
  output logic                     mem_clken,
  input  logic [DATA_W-1:0]        mem_readdata
);
  localparam int BE_W = DATA_W / 8;

  logic [NREQ-1:0]      req_any;
  logic [REQ_IDX_W-1:0] win, rr_ptr_q, rr_ptr_d, rd_owner_q, rd_owner_d;
  logic                 any_req, grant, rdv_q, rdv_d;
  arb_cmd_t             cmd_sel, cmd_q, cmd_d;

  assign req_any = req_read | req_write;

  final_soc_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i (req_any),
    .ptr_i (rr_ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  assign grant = reset_n & ~freeze & ~reset_req & any_req;

  // Read+write together is decoded as a write.
  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == REQ_IDX_W'(i)) begin
        cmd_sel.addr  = req_address[i*ADDR_W +: ADDR_W];
        cmd_sel.be    = req_byteenable[i*BE_W +: BE_W];
        cmd_sel.wdata = req_writedata[i*DATA_W +: DATA_W];
        cmd_sel.we    = req_write[i];
      end
    end
  end

  always_comb begin
    cmd_d    = grant ? cmd_sel : cmd_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (win == REQ_IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
    rdv_d      = grant & ~cmd_sel.we;
    rd_owner_d = rdv_d ? win : rd_owner_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      rdv_q      <= 1'b0;
      rd_owner_q <= '0;
      cmd_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rdv_q      <= rdv_d;
      rd_owner_q <= rd_owner_d;
      cmd_q      <= cmd_d;
    end
  end

  always_comb begin
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && win == REQ_IDX_W'(i))       req_waitrequest[i]   = 1'b0;
      if (rdv_q && rd_owner_q == REQ_IDX_W'(i)) req_readdatavalid[i] = 1'b1;
    end
  end

  assign req_readdata   = mem_readdata;
  assign mem_address    = cmd_d.addr;
  assign mem_byteenable = cmd_d.be;
  assign mem_writedata  = cmd_d.wdata;
  assign mem_chipselect = grant;
  assign mem_write      = grant & cmd_sel.we;
  assign mem_clken      = ~reset_req;

  a_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(|(req_read & req_write)));
endmodule

// File: tb/tb_final_soc_onchip_mem_arbiter.sv
// Scoreboarded random + directed bench for the on-chip RAM arbiter with a behavioural RAM model.
module tb_final_soc_onchip_mem_arbiter;
  localparam int NREQ = 2, AW = 2, DW = 32, BW = 4;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ*AW-1:0] req_address;
  logic [NREQ*BW-1:0] req_byteenable;
  logic [NREQ-1:0]    req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [NREQ*DW-1:0] req_writedata;
  logic [DW-1:0]      req_readdata, mem_writedata, mem_readdata;
  logic               freeze, reset_req, mem_chipselect, mem_write, mem_clken;
  logic [AW-1:0]      mem_address;
  logic [BW-1:0]      mem_byteenable;

  final_soc_onchip_mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_address(req_address), .req_byteenable(req_byteenable),
    .req_read(req_read), .req_write(req_write), .req_writedata(req_writedata),
    .req_waitrequest(req_waitrequest), .req_readdatavalid(req_readdatavalid),
    .req_readdata(req_readdata), .freeze(freeze), .reset_req(reset_req),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Single-port RAM slave: registered q, byte-enabled writes.
  logic [DW-1:0] ram [4];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  // Reference model state
  typedef struct { int owner; logic [DW-1:0] data; int cyc; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [4];
  int            mptr = 0;
  int            cyc = 0;
  int            n_chk = 0, n_pass = 0;
  int            gcnt [NREQ];

  bit            p_rd [NREQ], p_wr [NREQ];
  logic [AW-1:0] p_addr [NREQ];
  logic [BW-1:0] p_be [NREQ];
  logic [DW-1:0] p_wd [NREQ];
  bit            tb_freeze = 0, tb_rreq = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One bus cycle: drive pending commands, predict the grant, check outputs, update model.
  task automatic step(input bit clr);
    int w;
    bit g;
    logic [NREQ-1:0] exp_wr;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_read[i]                 = p_rd[i];
      req_write[i]                = p_wr[i];
      req_address[i*AW +: AW]     = p_addr[i];
      req_byteenable[i*BW +: BW]  = p_be[i];
      req_writedata[i*DW +: DW]   = p_wd[i];
    end
    freeze = tb_freeze;
    reset_req = tb_rreq;
    #1;
    w = -1;
    g = reset_n && !tb_freeze && !tb_rreq;
    for (int k = 0; k < NREQ; k++) begin
      int i = (mptr + k) % NREQ;
      if (w < 0 && (p_rd[i] || p_wr[i])) w = i;
    end
    g = g && (w >= 0);
    exp_wr = '1;
    if (g) exp_wr[w] = 1'b0;
    chk("waitrequest", 64'(req_waitrequest), 64'(exp_wr));
    chk("chipselect", 64'(mem_chipselect), 64'(g));
    chk("mem_write", 64'(mem_write), 64'(g ? p_wr[w] : 1'b0));
    chk("mem_clken", 64'(mem_clken), 64'(!tb_rreq));
    for (int i = 0; i < NREQ; i++) gcnt[i] += int'(!req_waitrequest[i]);
    if (g) begin
      chk("mem_address", 64'(mem_address), 64'(p_addr[w]));
      if (p_wr[w]) begin
        chk("mem_byteenable", 64'(mem_byteenable), 64'(p_be[w]));
        chk("mem_writedata", 64'(mem_writedata), 64'(p_wd[w]));
        ref_mem[p_addr[w]] = merge(ref_mem[p_addr[w]], p_wd[w], p_be[w]);
      end else begin
        q.push_back('{owner: w, data: ref_mem[p_addr[w]], cyc: cyc + 1});
      end
      mptr = (w + 1) % NREQ;
      if (clr) begin p_rd[w] = 0; p_wr[w] = 0; end
    end
  endtask

  // Monitor: every cycle, readdatavalid must match the head of the expected-return queue.
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] e;
    if (reset_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = '0;
        e[q[0].owner] = 1'b1;
        chk("rdv_owner", 64'(req_readdatavalid), 64'(e));
        chk("readdata", 64'(req_readdata), 64'(q[0].data));
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("rdv_late", 64'(q[0].cyc), 64'(cyc));
        void'(q.pop_front());
      end else begin
        chk("rdv_idle", 64'(req_readdatavalid), 64'(0));
      end
    end
  end

  task automatic set_cmd(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
    p_rd[i] = !wr; p_wr[i] = wr; p_addr[i] = a; p_be[i] = be; p_wd[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram_q = '0;
    for (int i = 0; i < NREQ; i++) begin
      p_rd[i] = 0; p_wr[i] = 0; p_addr[i] = '0; p_be[i] = '0; p_wd[i] = '0; gcnt[i] = 0;
    end
    req_read = '0; req_write = '0; req_address = '0; req_byteenable = '0;
    req_writedata = '0; freeze = 1'b0; reset_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_waitrequest", 64'(req_waitrequest), 64'(2'b11));
    chk("rst_rdv", 64'(req_readdatavalid), 64'(0));
    chk("rst_chipselect", 64'(mem_chipselect), 64'(0));
    chk("rst_mem_write", 64'(mem_write), 64'(0));
    reset_n = 1'b1;

    // 1: write then read back through requester 0
    set_cmd(0, 1, 2'd1, 4'hF, 32'hDEADBEEF); step(1);
    set_cmd(0, 0, 2'd1, 4'h0, 32'h0);        step(1);
    step(1);

    // 2: both read continuously; equal share of grants
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    set_cmd(0, 0, 2'd1, 4'h0, 32'h0);
    set_cmd(1, 0, 2'd0, 4'h0, 32'h0);
    repeat (8) step(0);
    chk("fair_m0", 64'(gcnt[0]), 64'(4));
    chk("fair_m1", 64'(gcnt[1]), 64'(4));
    p_rd[0] = 0; p_rd[1] = 0;
    step(1);

    // 3: partial-byte write over all-ones
    set_cmd(1, 1, 2'd2, 4'hF, 32'hFFFFFFFF); step(1);
    set_cmd(1, 1, 2'd2, 4'b0101, 32'h11223344); step(1);
    set_cmd(1, 0, 2'd2, 4'h0, 32'h0); step(1);
    step(1);

    // 4: reset_req right after a read accept
    set_cmd(0, 0, 2'd1, 4'h0, 32'h0); step(1);
    tb_rreq = 1;
    set_cmd(1, 0, 2'd2, 4'h0, 32'h0);
    repeat (3) step(1);
    tb_rreq = 0;
    step(1); step(1);

    // 5: freeze blocks both, release grants the pointer owner
    tb_freeze = 1;
    set_cmd(0, 0, 2'd3, 4'h0, 32'h0);
    set_cmd(1, 0, 2'd0, 4'h0, 32'h0);
    repeat (3) step(1);
    tb_freeze = 0;
    repeat (3) step(1);

    // 6: reset_n in the cycle after a read accept drops the return
    set_cmd(0, 0, 2'd1, 4'h0, 32'h0); step(1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    q.delete();
    mptr = 0;
    #1;
    chk("rst6_rdv", 64'(req_readdatavalid), 64'(0));
    chk("rst6_waitrequest", 64'(req_waitrequest), 64'(2'b11));
    chk("rst6_chipselect", 64'(mem_chipselect), 64'(0));
    chk("rst6_mem_write", 64'(mem_write), 64'(0));
    reset_n = 1'b1;
    p_rd[0] = 0;
    step(1);

    // Random traffic; pending commands stay stable until granted
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_rd[i] && !p_wr[i] && ($urandom % 2 == 0))
          set_cmd(i, bit'($urandom % 2), AW'($urandom % 4), BW'($urandom), $urandom);
      end
      tb_freeze = ($urandom % 10 == 0);
      tb_rreq   = ($urandom % 10 == 0);
      step(1);
    end
    tb_freeze = 0; tb_rreq = 0;
    for (int i = 0; i < NREQ; i++) begin p_rd[i] = 0; p_wr[i] = 0; end
    repeat (3) step(1);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
